// File: rtl/wots_chain_if.sv
// rtl/wots_chain_if.sv - chain-request and SHA-256 request signal bundle for wots_chain
//
// Purpose: groups the chain-request handshake (controller <-> wots_chain) and the
// hash-core handshake (wots_chain <-> SHA-256) into one bundle.
//   slave  : view of wots_chain (responder on chain requests, requester on the hash core)
//   master : view of the environment (controllers plus hash core)
// Optional macro: WOTS_CHAIN_INTERMEDIATE_EN adds inter_step / inter_valid / inter_data.
interface wots_chain_if #(
    parameter int WOTS_W     = 16,
    parameter int WOTS_LOG_W = $clog2(WOTS_W),
    parameter int KEY_LEN    = 256
);
    logic                  start;
    logic [KEY_LEN-1:0]    input_key;
    logic [KEY_LEN-1:0]    input_data;
    logic [WOTS_LOG_W-1:0] start_step;
    logic [WOTS_LOG_W-1:0] end_step;
    logic [255:0]          hash_addr;
    logic                  busy;
    logic                  done;
    logic [KEY_LEN-1:0]    data_out;
    logic [255:0]          hash_addr_updated;
    logic                  hash_start;
    logic [1023:0]         hash_data_in;
    logic                  message_length;
    logic                  hash_done;
    logic [KEY_LEN-1:0]    hash_data_out;
`ifdef WOTS_CHAIN_INTERMEDIATE_EN
    logic [WOTS_LOG_W-1:0] inter_step;
    logic                  inter_valid;
    logic [KEY_LEN-1:0]    inter_data;

    modport slave (
        input  start, input_key, input_data, start_step, end_step, hash_addr,
        input  hash_done, hash_data_out, inter_step,
        output busy, done, data_out, hash_addr_updated,
        output hash_start, hash_data_in, message_length, inter_valid, inter_data
    );
    modport master (
        output start, input_key, input_data, start_step, end_step, hash_addr,
        output hash_done, hash_data_out, inter_step,
        input  busy, done, data_out, hash_addr_updated,
        input  hash_start, hash_data_in, message_length, inter_valid, inter_data
    );
`else
    modport slave (
        input  start, input_key, input_data, start_step, end_step, hash_addr,
        input  hash_done, hash_data_out,
        output busy, done, data_out, hash_addr_updated,
        output hash_start, hash_data_in, message_length
    );
    modport master (
        output start, input_key, input_data, start_step, end_step, hash_addr,
        output hash_done, hash_data_out,
        input  busy, done, data_out, hash_addr_updated,
        input  hash_start, hash_data_in, message_length
    );
`endif
endinterface

// File: rtl/wots_chain.sv
// rtl/wots_chain.sv - WOTS+ hash-chain walker driving a shared SHA-256 core
//
// Purpose: for each accepted request walks the chain from start_step to end_step
// inclusive; every step issues PRF(key), PRF(bitmask) and F to the hash core and
// the result of F becomes the next chain value.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   bus (slave)       : start/input_key/input_data/start_step/end_step/hash_addr in,
//                       busy/done/data_out/hash_addr_updated out,
//                       hash_start/hash_data_in/message_length out, hash_done/hash_data_out in
// Optional macro: WOTS_CHAIN_INTERMEDIATE_EN adds the intermediate-value tap
//   (inter_step in, inter_valid/inter_data out).
module wots_chain #(
    parameter int           WOTS_W                = 16,
    parameter int           WOTS_LOG_W            = $clog2(WOTS_W),
    parameter int           KEY_LEN               = 256,
    parameter logic [255:0] XMSS_HASH_PADDING_F   = 256'd0,
    parameter logic [255:0] XMSS_HASH_PADDING_PRF = 256'd3
) (
    input  logic       clk,
    input  logic       reset,
    wots_chain_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_WAIT_KEY, S_MASK, S_WAIT_MASK, S_F, S_WAIT_F, S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [KEY_LEN-1:0]    r_key, r_tmp, r_f_key, r_bm, r_data_out;
    logic [WOTS_LOG_W-1:0] r_step, r_end;
    logic [191:0]          r_addr_hi;     // ADRS words 0-5, passed through untouched
    logic [255:0]          r_addr_upd;

    logic                  w_zero_steps;
    logic                  w_last_step;
    logic [31:0]           w_hash_field;
    logic [255:0]          w_addr_key, w_addr_mask;
    logic [1023:0]         w_msg_key, w_msg_mask, w_msg_f;
    logic [1023:0]         w_msg;
    logic                  w_busy, w_done, w_hash_start;

    assign w_zero_steps = bus.start_step > bus.end_step;
    assign w_last_step  = r_step == r_end;

    // Address fields are overwritten, never incremented.
    assign w_hash_field = {{(32 - WOTS_LOG_W){1'b0}}, r_step};
    assign w_addr_key   = {r_addr_hi, w_hash_field, 32'd0};
    assign w_addr_mask  = {r_addr_hi, w_hash_field, 32'd1};

    assign w_msg_key  = {XMSS_HASH_PADDING_PRF, r_key, w_addr_key, 256'd0};
    assign w_msg_mask = {XMSS_HASH_PADDING_PRF, r_key, w_addr_mask, 256'd0};
    assign w_msg_f    = {XMSS_HASH_PADDING_F, r_f_key, r_tmp ^ r_bm, 256'd0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The message is decoded from the current state, so it stays stable through
    // the wait state until the core answers.
    always_comb begin
        w_next       = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_hash_start = 1'b0;
        w_msg        = '0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = w_zero_steps ? S_DONE : S_KEY;
                end
            end
            S_KEY: begin
                w_hash_start = 1'b1;
                w_msg        = w_msg_key;
                w_next       = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                w_msg = w_msg_key;
                if (bus.hash_done) begin
                    w_next = S_MASK;
                end
            end
            S_MASK: begin
                w_hash_start = 1'b1;
                w_msg        = w_msg_mask;
                w_next       = S_WAIT_MASK;
            end
            S_WAIT_MASK: begin
                w_msg = w_msg_mask;
                if (bus.hash_done) begin
                    w_next = S_F;
                end
            end
            S_F: begin
                w_hash_start = 1'b1;
                w_msg        = w_msg_f;
                w_next       = S_WAIT_F;
            end
            S_WAIT_F: begin
                w_msg = w_msg_f;
                if (bus.hash_done) begin
                    w_next = w_last_step ? S_DONE : S_KEY;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key      <= '0;
            r_tmp      <= '0;
            r_f_key    <= '0;
            r_bm       <= '0;
            r_data_out <= '0;
            r_step     <= '0;
            r_end      <= '0;
            r_addr_hi  <= '0;
            r_addr_upd <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_key     <= bus.input_key;
                        r_tmp     <= bus.input_data;
                        r_step    <= bus.start_step;
                        r_end     <= bus.end_step;
                        r_addr_hi <= bus.hash_addr[255:64];
                        if (w_zero_steps) begin
                            r_data_out <= bus.input_data;
                            r_addr_upd <= bus.hash_addr;
                        end
                    end
                end
                S_WAIT_KEY: begin
                    if (bus.hash_done) begin
                        r_f_key <= bus.hash_data_out;
                    end
                end
                S_MASK: begin
                    r_addr_upd <= w_addr_mask;
                end
                S_WAIT_MASK: begin
                    if (bus.hash_done) begin
                        r_bm <= bus.hash_data_out;
                    end
                end
                S_WAIT_F: begin
                    if (bus.hash_done) begin
                        r_tmp <= bus.hash_data_out;
                        // Compare before incrementing so end_step = W-1 never wraps.
                        if (w_last_step) begin
                            r_data_out <= bus.hash_data_out;
                        end else begin
                            r_step <= r_step + WOTS_LOG_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef WOTS_CHAIN_INTERMEDIATE_EN
    logic               r_inter_valid;
    logic [KEY_LEN-1:0] r_inter_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inter_valid <= 1'b0;
            r_inter_data  <= '0;
        end else begin
            r_inter_valid <= 1'b0;
            if (r_state == S_WAIT_F && bus.hash_done && r_step == bus.inter_step) begin
                r_inter_valid <= 1'b1;
                r_inter_data  <= bus.hash_data_out;
            end
        end
    end

    assign bus.inter_valid = r_inter_valid;
    assign bus.inter_data  = r_inter_data;
`endif

    assign bus.busy              = w_busy;
    assign bus.done              = w_done;
    assign bus.data_out          = r_data_out;
    assign bus.hash_addr_updated = r_addr_upd;
    assign bus.hash_start        = w_hash_start;
    assign bus.hash_data_in      = w_msg;
    assign bus.message_length    = 1'b0;

endmodule

// File: tb/tb_wots_chain.sv
// tb/tb_wots_chain.sv - self-checking bench for wots_chain with a behavioural chain model
module tb_wots_chain;
    localparam int           W       = 16;
    localparam int           KL      = 256;
    localparam logic [255:0] PAD_F   = 256'd0;
    localparam logic [255:0] PAD_PRF = 256'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wots_chain_if #(.WOTS_W(W), .KEY_LEN(KL)) bus ();

    wots_chain #(.WOTS_W(W), .KEY_LEN(KL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [1023:0] exp_msg[$];
    logic [255:0]  exp_data, exp_addr, exp_inter;
    int            exp_lat;
    bit            in_tx = 0, done_seen = 0, chk_en = 0;
    int            start_cyc = 0, done_cyc = 0;
    int            n_hs = 0, n_iv = 0;
    int            lat = 4, gen = 0, hreq = 0;
    logic [3:0]    inter_sel = 4'd7;

    bit            hw_done = 0, spur = 0, spur_arm = 0;
    logic [255:0]  hw_data = '0, spur_data = '0;

    assign bus.hash_done     = hw_done | spur;
    assign bus.hash_data_out = spur ? spur_data : hw_data;
`ifdef WOTS_CHAIN_INTERMEDIATE_EN
    assign bus.inter_step = inter_sel;
`endif

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Stand-in for SHA-256: any deterministic mixing of all message words.
    function automatic logic [255:0] toy_h(input logic [1023:0] m);
        logic [255:0] a, b, c, d, h;
        a = m[1023:768]; b = m[767:512]; c = m[511:256]; d = m[255:0];
        h = a ^ {b[242:0], b[255:243]} ^ {c[200:0], c[255:201]} ^ d
            ^ 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
        h = h + {h[127:0], h[255:128]} + c;
        h = h ^ (h >> 11);
        return h;
    endfunction

    // gen_chain: expected request sequence, result, final address and latency.
    task automatic model_chain(input logic [255:0] k, d, a, input logic [3:0] ss, es);
        logic [255:0]  tmp, fk, bm, ad;
        logic [1023:0] m;
        int            n;
        tmp = d;
        exp_addr = a;
        n = 0;
        for (int s = int'(ss); s <= int'(es); s++) begin
            ad = a; ad[63:32] = s; ad[31:0] = 32'd0;
            m = {PAD_PRF, k, ad, 256'd0}; exp_msg.push_back(m); fk = toy_h(m);
            ad[31:0] = 32'd1; exp_addr = ad;
            m = {PAD_PRF, k, ad, 256'd0}; exp_msg.push_back(m); bm = toy_h(m);
            m = {PAD_F, fk, tmp ^ bm, 256'd0}; exp_msg.push_back(m); tmp = toy_h(m);
            if (s == int'(inter_sel)) exp_inter = tmp;
            n++;
        end
        exp_data = tmp;
        exp_lat  = 3 * n * (lat + 1) + 2;   // counted inclusively, start cycle through done cycle
    endtask

    task automatic kick(input logic [255:0] k, d, a, input logic [3:0] ss, es);
        hreq = 0;
        done_seen = 0;
        @(posedge clk); #1;
        bus.input_key = k; bus.input_data = d; bus.hash_addr = a;
        bus.start_step = ss; bus.end_step = es; bus.start = 1'b1;
        start_cyc = cyc; in_tx = 1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.input_key = rand256(); bus.input_data = rand256(); bus.hash_addr = rand256();
        bus.start_step = 4'($urandom); bus.end_step = 4'($urandom);
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && !done_seen; i++) @(posedge clk);
        if (!done_seen) check("done_timeout", 1'b0, 1'b1);
        #1;
    endtask

    task automatic tx(input logic [255:0] k, d, a, input logic [3:0] ss, es);
        model_chain(k, d, a, ss, es);
        kick(k, d, a, ss, es);
        wait_done(exp_lat + 40);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_hash_start"}, bus.hash_start, 1'b0);
        check({tag, "_data_out"}, bus.data_out, 256'd0);
        check({tag, "_addr_upd"}, bus.hash_addr_updated, 256'd0);
        check({tag, "_msg"}, bus.hash_data_in[511:0] | bus.hash_data_in[1023:512], 512'd0);
        check({tag, "_msg_len"}, bus.message_length, 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Hash core: answers each request L cycles later with toy_h of the message.
    initial begin
        int           g;
        logic [255:0] dig;
        forever begin
            @(negedge clk);
            if (bus.hash_start === 1'b1 && !reset) begin
                g = gen;
                dig = toy_h(bus.hash_data_in);
                if (spur_arm && (hreq % 3) == 1) begin
                    spur_data = rand256();
                    spur = 1;
                end
                hreq++;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    spur = 0;
                end
                if (g == gen) begin
                    hw_data = dig;
                    hw_done = 1;
                end
                @(posedge clk); #1;
                hw_done = 0;
            end
        end
    end

    // Compare process: busy window, every hash request, and completion results.
    initial begin
        logic [1023:0] m;
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                check("busy", bus.busy, in_tx && cyc > start_cyc);
                if (bus.hash_start) begin
                    n_hs++;
                    check("msg_len", bus.message_length, 1'b0);
                    if (exp_msg.size() == 0) begin
                        check("extra_hash_start", 1'b1, 1'b0);
                    end else begin
                        m = exp_msg.pop_front();
                        check("msg_hi", bus.hash_data_in[1023:512], m[1023:512]);
                        check("msg_lo", bus.hash_data_in[511:0], m[511:0]);
                    end
                end
                if (bus.done) begin
                    check("done_in_tx", in_tx, 1'b1);
                    check("data_out", bus.data_out, exp_data);
                    check("addr_upd", bus.hash_addr_updated, exp_addr);
                    check("latency", cyc - start_cyc + 1, exp_lat);
                    check("pending_reqs", exp_msg.size(), 0);
                    done_cyc = cyc;
                    in_tx = 0;
                    done_seen = 1;
                end
`ifdef WOTS_CHAIN_INTERMEDIATE_EN
                if (bus.inter_valid) begin
                    n_iv++;
                    check("inter_data", bus.inter_data, exp_inter);
                end
`endif
            end
        end
    end

    initial begin
        int           base;
        int           iv_base;
        int           i;
        logic [255:0] k, d, a;
        logic [3:0]   ss, es;

        bus.start = 0; bus.input_key = '0; bus.input_data = '0; bus.hash_addr = '0;
        bus.start_step = '0; bus.end_step = '0;

        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 0;
        chk_en = 1;

        // Full chain 0..14, L=4.
        lat = 4;
        base = n_hs; iv_base = n_iv;
        k = rand256(); d = rand256(); a = rand256();
        tx(k, d, a, 4'd0, 4'd14);
        check("full_hs_count", n_hs - base, 45);
        check("full_latency_lit", done_cyc - start_cyc + 1, 227);
        check("full_addr_hash_lit", bus.hash_addr_updated[63:32], 32'd14);
        check("full_addr_kam_lit", bus.hash_addr_updated[31:0], 32'd1);
        check("full_addr_hi", bus.hash_addr_updated[255:64], a[255:64]);
`ifdef WOTS_CHAIN_INTERMEDIATE_EN
        check("inter_pulses", n_iv - iv_base, 1);
`endif

        // Single step 3..3.
        lat = 2;
        base = n_hs;
        k = rand256(); d = rand256(); a = rand256();
        model_chain(k, d, a, 4'd3, 4'd3);
        check("single_key_hash_field", exp_msg[0][319:288], 32'd3);
        check("single_key_kam_field", exp_msg[0][287:256], 32'd0);
        check("single_mask_kam_field", exp_msg[1][287:256], 32'd1);
        kick(k, d, a, 4'd3, 4'd3);
        wait_done(exp_lat + 40);
        check("single_hs_count", n_hs - base, 3);

        // Zero steps 5..4.
        base = n_hs;
        d = {32{8'hAA}};
        a = rand256();
        tx(rand256(), d, a, 4'd5, 4'd4);
        check("zero_data_lit", bus.data_out, {32{8'hAA}});
        check("zero_latency_lit", done_cyc - start_cyc + 1, 2);
        check("zero_hs_count", n_hs - base, 0);
        check("zero_addr", bus.hash_addr_updated, a);

        // Full-width top step: 15..15 must not wrap.
        lat = 1;
        tx(rand256(), rand256(), rand256(), 4'd15, 4'd15);

        // Spurious hash_done in MASK plus a second start mid-chain.
        lat = 3;
        spur_arm = 1;
        k = rand256(); d = rand256(); a = rand256();
        model_chain(k, d, a, 4'd2, 4'd9);
        kick(k, d, a, 4'd2, 4'd9);
        repeat (30) @(posedge clk);
        #1;
        bus.input_key = rand256(); bus.input_data = rand256(); bus.hash_addr = rand256();
        bus.start_step = 4'd0; bus.end_step = 4'd15; bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        wait_done(exp_lat + 40);
        spur_arm = 0;

        // Reset during WAIT_F.
        lat = 3;
        base = n_hs;
        k = rand256(); d = rand256(); a = rand256();
        model_chain(k, d, a, 4'd0, 4'd3);
        kick(k, d, a, 4'd0, 4'd3);
        i = 0;
        while (n_hs < base + 3 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("reach_wait_f", n_hs >= base + 3, 1'b1);
        #2;
        chk_en = 0;
        gen++;
        reset = 1;
        #1;
        check_all_zero("midreset");
        exp_msg.delete();
        in_tx = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        repeat (lat + 3) @(posedge clk);
        #1;
        chk_en = 1;
        tx(rand256(), rand256(), rand256(), 4'd1, 4'd6);

        // Randomized requests, including start_step > end_step.
        for (int t = 0; t < 6; t++) begin
            lat = $urandom_range(1, 5);
            ss = 4'($urandom_range(0, 15));
            es = 4'($urandom_range(0, 15));
            tx(rand256(), rand256(), rand256(), ss, es);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wots_chain.md
# wots_chain

WOTS+ chaining engine. It is the responder on the chain-request interface that the public-key, signing and verification controllers drive. For each request it walks a hash chain from `start_step` to `end_step` inclusive, issuing three requests per step to the shared SHA-256 core: PRF key, PRF bitmask, then F. It returns the chain value and the final hash address.

## Interface
Parameters:
- `WOTS_W`, 16: Winternitz parameter.
- `WOTS_LOG_W`, `CLOG2(WOTS_W)`: width of the step fields.
- `KEY_LEN`, 256: width of keys and chain values.
- `XMSS_HASH_PADDING_F`, 256'd0: domain pad for F.
- `XMSS_HASH_PADDING_PRF`, 256'd3: domain pad for PRF.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `input_key` in KEY_LEN: public seed.
- `input_data` in KEY_LEN: chain start value.
- `start_step` in WOTS_LOG_W: first step index.
- `end_step` in WOTS_LOG_W: last step index, inclusive.
- `hash_addr` in 256: ADRS. Word 0 is at [255:224]. Hash field is [63:32]; keyAndMask field is [31:0].
- `busy` out 1: request in progress.
- `done` out 1: one-cycle completion pulse.
- `data_out` out KEY_LEN: chain result, held until the next accepted `start`.
- `hash_addr_updated` out 256: ADRS used for the last PRF call, held.
- `hash_start` out 1: one-cycle SHA-256 request.
- `hash_data_in` out 1024: message; valid while `hash_start`=1 and held until `hash_done`.
- `message_length` out 1: tied to 0 (768-bit message).
- `hash_done` in 1: one-cycle pulse; `hash_data_out` is valid in that same cycle.
- `hash_data_out` in KEY_LEN: digest.

## Operation
- FSM states: IDLE, KEY, WAIT_KEY, MASK, WAIT_MASK, F, WAIT_F, DONE.
- **IDLE**
  - On `start`, latch `input_key` into `key`, `input_data` into `tmp`, `start_step` into `step`, `end_step` into `end`, and `hash_addr` into `addr`.
  - If `start_step` > `end_step`, go to DONE. In that case `data_out`=`input_data` and `hash_addr_updated`=`hash_addr`.
  - Otherwise go to KEY.
- **KEY**
  - `hash_data_in` = {PRF pad, `key`, `addr` with hash=`step` and keyAndMask=0, 256'b0}.
  - Go to WAIT_KEY.
- **WAIT_KEY:** on `hash_done`, latch `f_key` from `hash_data_out`, then go to MASK.
- **MASK**
  - Same as KEY, but keyAndMask=1.
  - `hash_addr_updated` takes this address.
  - Go to WAIT_MASK.
- **WAIT_MASK:** on `hash_done`, latch `bm` from `hash_data_out`, then go to F.
- **F**
  - `hash_data_in` = {F pad, `f_key`, `tmp`^`bm`, 256'b0}.
  - Go to WAIT_F.
- **WAIT_F**
  - On `hash_done`, `tmp` <= `hash_data_out`.
  - If `step`==`end`, go to DONE. Otherwise `step`+1 and go to KEY.
  - `step` is compared before it is incremented, so `end_step`=W-1 never wraps.
- **DONE:** `done`=1, `data_out`=`tmp`; go to IDLE.
- `hash_start` is 1 only in KEY, MASK and F.
- `busy` is 1 in every state except IDLE.
- `hash_done` outside the WAIT states is ignored.
- `start` while `busy`=1 is ignored.
- Address fields are only overwritten, never added to. Words 0–5 pass through unchanged.
- Reset (asynchronous, any state) forces IDLE. All outputs reset to 0: `busy`, `done`, `hash_start`, `data_out`, `hash_addr_updated`, `hash_data_in`, `message_length`.

## Timing
- `start` at cycle 0 puts the FSM in KEY at cycle 1, with `hash_start`=1 in cycle 1.
- A request state lasts exactly one cycle. Each hash costs 1 + L cycles, where L is the hasher latency to `hash_done` (L ≥ 1).
- Total latency is 3·N·(L+1) + 2 cycles, with N = `end_step` − `start_step` + 1.
- For the zero-step case, `done` is at cycle 2.
- `done` and the valid `data_out` appear one cycle after the final `hash_done`. `busy` falls in the cycle after `done`.
- A new `start` is accepted in the first IDLE cycle.

## Configuration
- `WOTS_CHAIN_INTERMEDIATE_EN`
  - **Defined:** adds input `inter_step` [WOTS_LOG_W], and outputs `inter_valid` [1] and `inter_data` [KEY_LEN].
    - `inter_valid` pulses for one cycle, in the cycle after the WAIT_F `hash_done` of the step equal to `inter_step`.
    - `inter_data` holds that step's value.
    - This lets signing capture a chain position during a pk walk.
  - **Undefined:** the ports and logic are absent. Core behaviour is identical.

## Test plan
- **Full chain.** W=16, `start_step`=0, `end_step`=14, hasher L=4.
  - Exactly 45 `hash_start` pulses.
  - `done` at cycle 3·15·5+2 = 227.
  - `data_out` matches the software `gen_chain` model.
  - `hash_addr_updated`[63:32]=14 and [31:0]=1.
- **Single step.** `start_step`=`end_step`=3.
  - 3 requests: PRF with addr hash=3/kam=0, then hash=3/kam=1, then F.
  - F message [767:512]=`f_key` and [511:256]=`input_data`^`bm`.
- **Zero steps.** `start_step`=5, `end_step`=4, `input_data`=256'hAA…AA.
  - `done` at cycle 2, `data_out`=AA…AA, no `hash_start`.
- **Busy / spurious inputs.**
  - A second `start` mid-chain is ignored.
  - A spurious `hash_done` in state MASK is ignored.
  - Result is unchanged versus a clean run.
- **Reset mid-operation.** Assert `reset` during WAIT_F.
  - All outputs read 0 immediately.
  - A following request completes correctly.
- **Intermediate tap.** With `WOTS_CHAIN_INTERMEDIATE_EN`, run 0..14 with `inter_step`=7.
  - One `inter_valid` pulse.
  - `inter_data` equals the model value after step 7.
